// File: rtl/avr_prefetch_if.sv
// avr_prefetch_if: program-memory, instruction-delivery and redirect signals of the AVR fetch unit
interface avr_prefetch_if #(
  parameter int PC_W = 16
);
  logic [PC_W-1:0] prog_addr;
  logic            prog_req;
  logic [15:0]     prog_data;
  logic [15:0]     instr;
  logic [15:0]     instr_ext;
  logic            instr_long;
  logic [PC_W-1:0] instr_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic            jmp_valid;
  logic            jmp_rel;
  logic [PC_W-1:0] jmp_target;
  modport master (
    output prog_addr, prog_req, instr, instr_ext, instr_long, instr_pc, instr_valid,
    input  prog_data, instr_ready, jmp_valid, jmp_rel, jmp_target
  );
  modport slave (
    input  prog_addr, prog_req, instr, instr_ext, instr_long, instr_pc, instr_valid,
    output prog_data, instr_ready, jmp_valid, jmp_rel, jmp_target
  );
endinterface

// File: rtl/avr_prefetch_unit.sv
// avr_prefetch_unit: AVR instruction prefetch queue; define AVR_FETCH_LONG_EN to pair 32-bit instructions
module avr_prefetch_unit #(
  parameter int              PC_W    = 16,
  parameter int              DEPTH   = 4,
  parameter logic [PC_W-1:0] RST_VEC = '0
) (
  input logic            CLK,
  input logic            RST,
  avr_prefetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [PC_W-1:0] fpc_q, fpc_d, iaddr_q, iaddr_d, head_pc, step, tgt;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic            inflight_q, inflight_d;
  logic [15:0]     word_q [DEPTH];
  logic [PC_W-1:0] wpc_q [DEPTH];
  logic [15:0]     head, second;
  logic            nonempty, has2, long_w, push, pop;
  // head decode, handshake outputs, redirect target and queue next-state
  always_comb begin
    head     = word_q[rd_q];
    second   = word_q[rd_q + AW'(1)];
    head_pc  = wpc_q[rd_q];
    nonempty = count_q != '0;
    has2     = count_q >= CW'(2);
`ifdef AVR_FETCH_LONG_EN
    long_w   = nonempty && ((head[15:9] == 7'b1001010 && head[3:2] == 2'b11) ||
                            (head[15:10] == 6'b100100 && head[3:0] == 4'h0));
`else
    long_w   = 1'b0;
`endif
    bus.instr_long  = !RST && long_w;
    bus.instr_valid = !RST && nonempty && (!long_w || has2);
    bus.instr       = nonempty ? head : 16'h0000;
    bus.instr_ext   = (long_w && has2) ? second : 16'h0000;
    bus.instr_pc    = nonempty ? head_pc : '0;
    bus.prog_req    = !RST && !bus.jmp_valid && (count_q + CW'(inflight_q)) < CW'(DEPTH);
    bus.prog_addr   = fpc_q;
    step       = long_w ? PC_W'(2) : PC_W'(1);
    tgt        = bus.jmp_rel ? bus.instr_pc + step + bus.jmp_target : bus.jmp_target;
    push       = inflight_q && !bus.jmp_valid;
    pop        = bus.instr_valid && bus.instr_ready;
    fpc_d      = bus.jmp_valid ? tgt : fpc_q + PC_W'(bus.prog_req);
    inflight_d = bus.prog_req;
    iaddr_d    = fpc_q;
    rd_d       = bus.jmp_valid ? '0 : rd_q + (pop ? (long_w ? AW'(2) : AW'(1)) : '0);
    wr_d       = bus.jmp_valid ? '0 : wr_q + AW'(push);
    count_d    = bus.jmp_valid ? '0 :
                 count_q + CW'(push) - (pop ? (long_w ? CW'(2) : CW'(1)) : '0);
  end
  // control state: fetch pointer, occupancy, queue pointers, outstanding request
  always_ff @(posedge CLK) begin
    if (RST) begin
      fpc_q      <= RST_VEC;
      count_q    <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      inflight_q <= 1'b0;
    end else begin
      fpc_q      <= fpc_d;
      count_q    <= count_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      inflight_q <= inflight_d;
    end
  end
  // queue storage: the returning word is written together with the address it was fetched from
  always_ff @(posedge CLK) begin
    iaddr_q <= iaddr_d;
    if (push) begin
      word_q[wr_q] <= bus.prog_data;
      wpc_q[wr_q]  <= iaddr_q;
    end
  end
endmodule
